datapath_p: RTL and testbench



---
 rtl/datapath_p_if.sv | 21 ++
 rtl/datapath_p.sv | 213 +++++++++++++++++++++
 tb/tb_datapath_p.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_p_if.sv
// Memory request/acknowledge bus between datapath_p (master) and the memory/IO subsystem (slave).
interface datapath_p_if #(
  parameter int WIDTH = 16
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/datapath_p.sv
// SLC-3 datapath with request/ack memory FSM, sticky bus-contention flag and registered LEDs.
// Optional macro DATAPATH_MEM_TIMEOUT_EN enables the memory-ack timeout counter and mem_err.
module datapath_p #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
  input  logic             GatePC, GateMDR, GateALU, GateMARMUX,
  input  logic             ADDR1MUX_SELECT, DRMUX_SELECT, SR1MUX_SELECT, SR2MUX_SELECT,
  input  logic [1:0]       PCMUX_SELECT, ADDR2MUX_SELECT, ALUK,
  input  logic             mem_rd_start,
  input  logic             mem_wr_start,
  datapath_p_if.master     mem,
  output logic             mem_busy,
  output logic             mem_done,
  output logic             mem_err,
  output logic             bus_err,
  output logic             BEN_OUT,
  output logic [2:0]       CC,
  output logic [WIDTH-1:0] PC_OUT, IR_OUT, MAR_OUT, MDR_OUT,
  output logic [11:0]      LED
);

  if (WIDTH < 16 || TIMEOUT < 1) begin : g_bad_param
    $error("datapath_p: WIDTH must be >= 16 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} mem_state_t;

  function automatic logic [WIDTH-1:0] sext11(input logic [10:0] v);
    return {{(WIDTH-11){v[10]}}, v};
  endfunction
  function automatic logic [WIDTH-1:0] sext9(input logic [8:0] v);
    return {{(WIDTH-9){v[8]}}, v};
  endfunction
  function automatic logic [WIDTH-1:0] sext6(input logic [5:0] v);
    return {{(WIDTH-6){v[5]}}, v};
  endfunction
  function automatic logic [WIDTH-1:0] sext5(input logic [4:0] v);
    return {{(WIDTH-5){v[4]}}, v};
  endfunction
  function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1])    return 3'b100;
    else if (v == '0)  return 3'b010;
    else               return 3'b001;
  endfunction

  logic [WIDTH-1:0] pc, ir, mar, mdr, bus, pc_nxt;
  logic [WIDTH-1:0] sr1_val, sr2_val, alu_out, addr1_val, addr2_val, adder_out;
  logic [WIDTH-1:0] regs [8];
  logic [WIDTH-1:0] addr_q, wdata_q;
  logic [2:0]       dr, sr1, cc;
  logic [11:0]      led;
  logic             ben, bus_conflict, bus_err_q, ack_hit;
  mem_state_t       state, state_nxt;

  assign dr        = DRMUX_SELECT  ? ir[11:9] : 3'd7;
  assign sr1       = SR1MUX_SELECT ? ir[8:6]  : ir[11:9];
  assign sr1_val   = regs[sr1];
  assign sr2_val   = SR2MUX_SELECT ? regs[ir[2:0]] : sext5(ir[4:0]);
  assign addr1_val = ADDR1MUX_SELECT ? pc : sr1_val;
  assign adder_out = addr1_val + addr2_val;

  always_comb begin
    case (ADDR2MUX_SELECT)
      2'b00:   addr2_val = sext11(ir[10:0]);
      2'b01:   addr2_val = sext9(ir[8:0]);
      2'b10:   addr2_val = sext6(ir[5:0]);
      default: addr2_val = '0;
    endcase
  end

  always_comb begin
    case (ALUK)
      2'b00:   alu_out = sr1_val + sr2_val;
      2'b01:   alu_out = sr1_val & sr2_val;
      2'b10:   alu_out = ~sr1_val;
      default: alu_out = sr1_val;
    endcase
  end

  always_comb begin
    case (PCMUX_SELECT)
      2'b00:   pc_nxt = bus;
      2'b01:   pc_nxt = adder_out;
      2'b10:   pc_nxt = pc + WIDTH'(1);
      default: pc_nxt = pc;
    endcase
  end

  // Multiple drivers would short on a real tri-state bus: drive zero and flag it instead.
  always_comb begin
    bus          = '0;
    bus_conflict = 1'b0;
    case ({GatePC, GateMDR, GateALU, GateMARMUX})
      4'b0000: bus = '0;
      4'b1000: bus = pc;
      4'b0100: bus = mdr;
      4'b0010: bus = alu_out;
      4'b0001: bus = adder_out;
      default: bus_conflict = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc        <= '0;
      ir        <= '0;
      mar       <= '0;
      cc        <= 3'b010;
      ben       <= 1'b0;
      led       <= '0;
      bus_err_q <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (LD_PC)        pc        <= pc_nxt;
      if (LD_IR)        ir        <= bus;
      if (LD_MAR)       mar       <= bus;
      if (LD_REG)       regs[dr]  <= bus;
      if (LD_CC)        cc        <= nzp_of(bus);
      if (LD_BEN)       ben       <= |(ir[11:9] & cc);
      if (LD_LED)       led       <= ir[11:0];
      if (bus_conflict) bus_err_q <= 1'b1;
    end
  end

`ifdef DATAPATH_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             to_hit, mem_err_q;
`endif

  always_comb begin
    state_nxt = state;
    ack_hit   = 1'b0;
`ifdef DATAPATH_MEM_TIMEOUT_EN
    to_hit    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (mem_rd_start)      state_nxt = RD;
        else if (mem_wr_start) state_nxt = WR;
      end
      RD, WR: begin
        if (mem.mem_ack) begin
          ack_hit   = 1'b1;
          state_nxt = DONE;
        end
`ifdef DATAPATH_MEM_TIMEOUT_EN
        // An ack arriving on the timeout edge takes precedence over the timeout.
        else if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
          to_hit    = 1'b1;
          state_nxt = DONE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      mdr     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef DATAPATH_MEM_TIMEOUT_EN
      to_cnt    <= '0;
      mem_err_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && (mem_rd_start || mem_wr_start)) begin
        addr_q <= mar;
        if (!mem_rd_start) wdata_q <= mdr;
      end
      if (state == RD && ack_hit)        mdr <= mem.mem_rdata;
`ifdef DATAPATH_MEM_TIMEOUT_EN
      else if (state == RD && to_hit)    mdr <= '0;
`endif
      else if (LD_MDR && state == IDLE)  mdr <= bus;
`ifdef DATAPATH_MEM_TIMEOUT_EN
      if ((state == RD || state == WR) && state_nxt == state) to_cnt <= to_cnt + CNT_W'(1);
      else                                                      to_cnt <= '0;
      if (to_hit) mem_err_q <= 1'b1;
`endif
    end
  end

`ifdef DATAPATH_MEM_TIMEOUT_EN
  assign mem_err = mem_err_q;
`else
  assign mem_err = 1'b0;
`endif

  assign mem.mem_req   = (state == RD) || (state == WR);
  assign mem.mem_we    = (state == WR);
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem_busy      = (state != IDLE);
  assign mem_done      = (state == DONE);
  assign bus_err       = bus_err_q;
  assign BEN_OUT       = ben;
  assign CC            = cc;
  assign PC_OUT        = pc;
  assign IR_OUT        = ir;
  assign MAR_OUT       = mar;
  assign MDR_OUT       = mdr;
  assign LED           = led;

endmodule

// File: tb/tb_datapath_p.sv
// Self-checking bench for datapath_p: register/ALU/bus paths plus memory handshake scoreboard.
module tb_datapath_p;
`ifdef DATAPATH_MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 15;
`endif
  localparam int W = 16;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic ADDR1MUX_SELECT, DRMUX_SELECT, SR1MUX_SELECT, SR2MUX_SELECT;
  logic [1:0] PCMUX_SELECT, ADDR2MUX_SELECT, ALUK;
  logic mem_rd_start, mem_wr_start;
  logic mem_busy, mem_done, mem_err, bus_err, BEN_OUT;
  logic [2:0] CC;
  logic [W-1:0] PC_OUT, IR_OUT, MAR_OUT, MDR_OUT;
  logic [11:0] LED;

  datapath_p_if #(.WIDTH(W)) mem();

  datapath_p #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .ADDR1MUX_SELECT(ADDR1MUX_SELECT), .DRMUX_SELECT(DRMUX_SELECT),
    .SR1MUX_SELECT(SR1MUX_SELECT), .SR2MUX_SELECT(SR2MUX_SELECT),
    .PCMUX_SELECT(PCMUX_SELECT), .ADDR2MUX_SELECT(ADDR2MUX_SELECT), .ALUK(ALUK),
    .mem_rd_start(mem_rd_start), .mem_wr_start(mem_wr_start),
    .mem(mem),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err), .bus_err(bus_err),
    .BEN_OUT(BEN_OUT), .CC(CC),
    .PC_OUT(PC_OUT), .IR_OUT(IR_OUT), .MAR_OUT(MAR_OUT), .MDR_OUT(MDR_OUT),
    .LED(LED)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] sb_q[$];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = '0;
    {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
    {ADDR1MUX_SELECT, DRMUX_SELECT, SR1MUX_SELECT, SR2MUX_SELECT} = '0;
    PCMUX_SELECT = 2'b00; ADDR2MUX_SELECT = 2'b00; ALUK = 2'b00;
    mem_rd_start = 1'b0; mem_wr_start = 1'b0;
  endtask

  // Memory read with the acknowledge arriving lat edges after the start edge.
  task automatic do_read(input logic [W-1:0] d, input int lat, output bit done_seen);
    mem.mem_rdata = d;
    mem_rd_start = 1'b1;
    tick();
    mem_rd_start = 1'b0;
    repeat (lat - 1) tick();
    mem.mem_ack = 1'b1;
    tick();
    mem.mem_ack = 1'b0;
    done_seen = mem_done;
    tick();
  endtask

  task automatic set_mdr(input logic [W-1:0] d);
    bit dn;
    do_read(d, 1, dn);
  endtask

  task automatic test_reset();
    Reset = 1'b1; clr();
    mem.mem_ack = 1'b0; mem.mem_rdata = '0;
    repeat (2) tick();
    Reset = 1'b0;
    n_cmp++; if ({PC_OUT, IR_OUT, MAR_OUT, MDR_OUT} !== '0) begin n_err++; $display("FAIL reset_regs: got %h %h %h %h required all 0", PC_OUT, IR_OUT, MAR_OUT, MDR_OUT); end
    n_cmp++; if (CC !== 3'b010) begin n_err++; $display("FAIL reset_cc: got %b required 010", CC); end
    n_cmp++; if ({BEN_OUT, LED} !== 13'd0) begin n_err++; $display("FAIL reset_ben_led: got %b %h required 0", BEN_OUT, LED); end
    n_cmp++; if ({mem.mem_req, mem.mem_we, mem_done, mem_busy, mem_err, bus_err} !== 6'd0) begin n_err++; $display("FAIL reset_flags: got %b required 000000", {mem.mem_req, mem.mem_we, mem_done, mem_busy, mem_err, bus_err}); end
  endtask

  task automatic test_pc_inc();
    LD_PC = 1'b1; PCMUX_SELECT = 2'b10;
    repeat (3) tick();
    clr();
    n_cmp++; if (PC_OUT !== 16'd3) begin n_err++; $display("FAIL pc_inc: got %h required 0003", PC_OUT); end
    n_cmp++; if ({CC, LED, bus_err, mem_err} !== {3'b010, 12'd0, 2'b00}) begin n_err++; $display("FAIL pc_inc_side: cc %b led %h errs %b%b", CC, LED, bus_err, mem_err); end
  endtask

  task automatic test_alu();
    set_mdr(16'h0200); GateMDR = 1'b1; LD_IR = 1'b1; tick(); clr();
    set_mdr(16'h0005); GateMDR = 1'b1; LD_REG = 1'b1; DRMUX_SELECT = 1'b1; tick(); clr();
    set_mdr(16'h0400); GateMDR = 1'b1; LD_IR = 1'b1; tick(); clr();
    set_mdr(16'hFFFA); GateMDR = 1'b1; LD_REG = 1'b1; DRMUX_SELECT = 1'b1; tick(); clr();
    set_mdr(16'h1042); GateMDR = 1'b1; LD_IR = 1'b1; tick(); clr();
    n_cmp++; if (IR_OUT !== 16'h1042) begin n_err++; $display("FAIL ir_load: got %h required 1042", IR_OUT); end
    // ADD R0,R1,R2
    GateALU = 1'b1; ALUK = 2'b00; SR1MUX_SELECT = 1'b1; SR2MUX_SELECT = 1'b1;
    DRMUX_SELECT = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; LD_MAR = 1'b1; tick(); clr();
    n_cmp++; if (MAR_OUT !== 16'hFFFF || CC !== 3'b100) begin n_err++; $display("FAIL alu_add: got %h cc %b required FFFF cc 100", MAR_OUT, CC); end
    GateALU = 1'b1; ALUK = 2'b11; SR1MUX_SELECT = 1'b0; LD_MAR = 1'b1; tick(); clr();
    n_cmp++; if (MAR_OUT !== 16'hFFFF) begin n_err++; $display("FAIL r0_readback: got %h required FFFF", MAR_OUT); end
    GateALU = 1'b1; ALUK = 2'b01; SR1MUX_SELECT = 1'b1; SR2MUX_SELECT = 1'b1; LD_MAR = 1'b1; LD_CC = 1'b1; tick(); clr();
    n_cmp++; if (MAR_OUT !== 16'h0000 || CC !== 3'b010) begin n_err++; $display("FAIL alu_and: got %h cc %b required 0000 cc 010", MAR_OUT, CC); end
    GateALU = 1'b1; ALUK = 2'b10; SR1MUX_SELECT = 1'b1; LD_MAR = 1'b1; tick(); clr();
    n_cmp++; if (MAR_OUT !== 16'hFFFA) begin n_err++; $display("FAIL alu_not: got %h required FFFA", MAR_OUT); end
    GateALU = 1'b1; ALUK = 2'b00; SR1MUX_SELECT = 1'b1; SR2MUX_SELECT = 1'b0; LD_MAR = 1'b1; LD_CC = 1'b1; tick(); clr();
    n_cmp++; if (MAR_OUT !== 16'h0007 || CC !== 3'b001) begin n_err++; $display("FAIL alu_imm: got %h cc %b required 0007 cc 001", MAR_OUT, CC); end
    LD_BEN = 1'b1; tick(); clr();
    n_cmp++; if (BEN_OUT !== 1'b0) begin n_err++; $display("FAIL ben_zero: got %b required 0", BEN_OUT); end
    GateMARMUX = 1'b1; ADDR1MUX_SELECT = 1'b1; ADDR2MUX_SELECT = 2'b01; LD_MAR = 1'b1; tick(); clr();
    n_cmp++; if (MAR_OUT !== 16'h0045) begin n_err++; $display("FAIL adder_pc_off9: got %h required 0045", MAR_OUT); end
    GateMARMUX = 1'b1; ADDR1MUX_SELECT = 1'b0; SR1MUX_SELECT = 1'b1; ADDR2MUX_SELECT = 2'b00; LD_MAR = 1'b1; tick(); clr();
    n_cmp++; if (MAR_OUT !== 16'h0047) begin n_err++; $display("FAIL adder_sr1_off11: got %h required 0047", MAR_OUT); end
    // Negative offsets and BEN with a matching NZP field
    set_mdr(16'h0FFF); GateMDR = 1'b1; LD_IR = 1'b1; tick(); clr();
    GateMARMUX = 1'b1; ADDR1MUX_SELECT = 1'b1; ADDR2MUX_SELECT = 2'b10; LD_MAR = 1'b1; LD_BEN = 1'b1; tick(); clr();
    n_cmp++; if (MAR_OUT !== 16'h0002 || BEN_OUT !== 1'b1) begin n_err++; $display("FAIL adder_neg_ben: got %h ben %b required 0002 ben 1", MAR_OUT, BEN_OUT); end
    LD_PC = 1'b1; PCMUX_SELECT = 2'b01; ADDR1MUX_SELECT = 1'b1; ADDR2MUX_SELECT = 2'b01; tick(); clr();
    n_cmp++; if (PC_OUT !== 16'h0002) begin n_err++; $display("FAIL pcmux_adder: got %h required 0002", PC_OUT); end
    LD_LED = 1'b1; tick(); clr();
    n_cmp++; if (LED !== 12'hFFF) begin n_err++; $display("FAIL led_load: got %h required FFF", LED); end
    set_mdr(16'hFFFF); GateMDR = 1'b1; LD_PC = 1'b1; PCMUX_SELECT = 2'b00; tick(); clr();
    LD_PC = 1'b1; PCMUX_SELECT = 2'b11; tick(); clr();
    n_cmp++; if (PC_OUT !== 16'hFFFF) begin n_err++; $display("FAIL pcmux_bus_hold: got %h required FFFF", PC_OUT); end
    LD_PC = 1'b1; PCMUX_SELECT = 2'b10; tick(); clr();
    n_cmp++; if (PC_OUT !== 16'h0000) begin n_err++; $display("FAIL pc_wrap: got %h required 0000", PC_OUT); end
  endtask

  task automatic test_read_handshake();
    int req_cycles = 0;
    int done_cnt = 0;
    bit we_seen = 1'b0;
    logic [W-1:0] exp;
    set_mdr(16'h0030); GateMDR = 1'b1; LD_MAR = 1'b1; tick(); clr();
    sb_q.push_back(16'h1234);
    mem_rd_start = 1'b1; mem_wr_start = 1'b1; tick(); clr();
    n_cmp++; if (mem.mem_addr !== 16'h0030) begin n_err++; $display("FAIL rd_addr: got %h required 0030", mem.mem_addr); end
    for (int c = 0; c < 3; c++) begin
      if (mem.mem_req === 1'b1) req_cycles++;
      if (mem.mem_we !== 1'b0) we_seen = 1'b1;
      if (mem_done === 1'b1) done_cnt++;
      if (c == 0) begin GatePC = 1'b1; LD_MAR = 1'b1; mem_wr_start = 1'b1; end
      if (c == 2) begin mem.mem_ack = 1'b1; mem.mem_rdata = 16'h1234; end
      tick(); clr();
      mem.mem_ack = 1'b0; mem.mem_rdata = 16'hDEAD;
    end
    n_cmp++; if (req_cycles !== 3) begin n_err++; $display("FAIL rd_req_cycles: got %0d required 3", req_cycles); end
    n_cmp++; if (mem.mem_req !== 1'b0 || mem_done !== 1'b1) begin n_err++; $display("FAIL rd_done_state: req %b done %b required 0 1", mem.mem_req, mem_done); end
    exp = sb_q.pop_front();
    n_cmp++; if (MDR_OUT !== exp) begin n_err++; $display("FAIL rd_mdr: got %h required %h", MDR_OUT, exp); end
    n_cmp++; if (MAR_OUT !== 16'h0000 || mem.mem_addr !== 16'h0030) begin n_err++; $display("FAIL mar_while_busy: mar %h addr %h required 0000 0030", MAR_OUT, mem.mem_addr); end
    if (mem_done === 1'b1) done_cnt++;
    mem_rd_start = 1'b1; tick(); clr();
    if (mem_done === 1'b1) done_cnt++;
    n_cmp++; if (mem_busy !== 1'b0) begin n_err++; $display("FAIL start_in_done: busy %b required 0", mem_busy); end
    tick();
    if (mem_done === 1'b1) done_cnt++;
    n_cmp++; if (done_cnt !== 1 || we_seen !== 1'b0 || mem_busy !== 1'b0) begin n_err++; $display("FAIL rd_done_pulse: pulses %0d we %b busy %b required 1 0 0", done_cnt, we_seen, mem_busy); end
    n_cmp++; if (MDR_OUT !== exp) begin n_err++; $display("FAIL rd_mdr_hold: got %h required %h", MDR_OUT, exp); end
  endtask

  task automatic test_bus_contention();
    set_mdr(16'hABCD); GateMDR = 1'b1; LD_MAR = 1'b1; tick(); clr();
    LD_MAR = 1'b1; tick(); clr();
    n_cmp++; if (MAR_OUT !== 16'h0000 || bus_err !== 1'b0) begin n_err++; $display("FAIL bus_idle: mar %h err %b required 0000 0", MAR_OUT, bus_err); end
    GateMDR = 1'b1; LD_MAR = 1'b1; tick(); clr();
    GatePC = 1'b1; GateALU = 1'b1; LD_MAR = 1'b1; tick(); clr();
    n_cmp++; if (MAR_OUT !== 16'h0000 || bus_err !== 1'b1) begin n_err++; $display("FAIL bus_conflict: mar %h err %b required 0000 1", MAR_OUT, bus_err); end
    repeat (5) tick();
    n_cmp++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL bus_err_sticky: got %b required 1", bus_err); end
  endtask

  task automatic test_write_reset();
    bit dn;
    logic [W-1:0] exp;
    set_mdr(16'h5A5A); GateMDR = 1'b1; LD_MAR = 1'b1; tick(); clr();
    set_mdr(16'hC3C3);
    mem_wr_start = 1'b1; tick(); clr();
    n_cmp++; if ({mem.mem_req, mem.mem_we, mem_busy} !== 3'b111 || mem.mem_addr !== 16'h5A5A || mem.mem_wdata !== 16'hC3C3) begin n_err++; $display("FAIL wr_start: req/we/busy %b addr %h wdata %h required 111 5A5A C3C3", {mem.mem_req, mem.mem_we, mem_busy}, mem.mem_addr, mem.mem_wdata); end
    GatePC = 1'b1; LD_MDR = 1'b1; tick(); clr();
    mem.mem_rdata = 16'hFFFF; mem.mem_ack = 1'b1; tick(); mem.mem_ack = 1'b0;
    n_cmp++; if (mem_done !== 1'b1 || mem.mem_req !== 1'b0 || MDR_OUT !== 16'hC3C3) begin n_err++; $display("FAIL wr_done: done %b req %b mdr %h required 1 0 C3C3", mem_done, mem.mem_req, MDR_OUT); end
    tick();
    mem_wr_start = 1'b1; tick(); clr();
    tick();
    Reset = 1'b1; tick(); Reset = 1'b0;
    n_cmp++; if (mem.mem_req !== 1'b0 || mem_busy !== 1'b0 || MDR_OUT !== 16'h0000) begin n_err++; $display("FAIL wr_reset: req %b busy %b mdr %h required 0 0 0000", mem.mem_req, mem_busy, MDR_OUT); end
    n_cmp++; if (bus_err !== 1'b0 || CC !== 3'b010 || PC_OUT !== 16'h0000 || LED !== 12'h000) begin n_err++; $display("FAIL reset_clears: bus_err %b cc %b pc %h led %h required 0 010 0000 000", bus_err, CC, PC_OUT, LED); end
    sb_q.push_back(16'h8001);
    do_read(16'h8001, 2, dn);
    exp = sb_q.pop_front();
    n_cmp++; if (MDR_OUT !== exp || dn !== 1'b1) begin n_err++; $display("FAIL read_after_reset: mdr %h done %b required %h 1", MDR_OUT, dn, exp); end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    logic [W-1:0] exp;
`ifdef DATAPATH_MEM_TIMEOUT_EN
    bit dn;
    sb_q.push_back(16'hABCD);
    do_read(16'hABCD, TO, dn);
    exp = sb_q.pop_front();
    n_cmp++; if (MDR_OUT !== exp || mem_err !== 1'b0 || dn !== 1'b1) begin n_err++; $display("FAIL ack_on_timeout_edge: mdr %h err %b done %b required %h 0 1", MDR_OUT, mem_err, dn, exp); end
    sb_q.push_back(16'h0000);
    mem.mem_rdata = 16'h7777;
    mem_rd_start = 1'b1; tick(); clr();
    for (int c = 0; c < 4 * TO && mem.mem_req === 1'b1; c++) begin
      req_cycles++;
      tick();
    end
    n_cmp++; if (req_cycles !== TO) begin n_err++; $display("FAIL timeout_req_cycles: got %0d required %0d", req_cycles, TO); end
    exp = sb_q.pop_front();
    n_cmp++; if (mem_done !== 1'b1 || mem_err !== 1'b1 || MDR_OUT !== exp) begin n_err++; $display("FAIL timeout_done: done %b err %b mdr %h required 1 1 %h", mem_done, mem_err, MDR_OUT, exp); end
    tick();
    n_cmp++; if (mem_busy !== 1'b0 || mem_err !== 1'b1) begin n_err++; $display("FAIL timeout_idle: busy %b err %b required 0 1", mem_busy, mem_err); end
`else
    exp = MDR_OUT;
    mem_rd_start = 1'b1; tick(); clr();
    for (int c = 0; c < 100; c++) begin
      if (mem.mem_req === 1'b1) req_cycles++;
      tick();
    end
    n_cmp++; if (req_cycles !== 100 || mem_err !== 1'b0) begin n_err++; $display("FAIL no_timeout_wait: req cycles %0d err %b required 100 0", req_cycles, mem_err); end
    n_cmp++; if (mem_done !== 1'b0 || MDR_OUT !== exp) begin n_err++; $display("FAIL no_timeout_state: done %b mdr %h required 0 %h", mem_done, MDR_OUT, exp); end
    Reset = 1'b1; tick(); Reset = 1'b0;
    n_cmp++; if (mem_busy !== 1'b0 || mem.mem_req !== 1'b0) begin n_err++; $display("FAIL no_timeout_reset: busy %b req %b required 0 0", mem_busy, mem.mem_req); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pc_inc();
    test_alu();
    test_read_handshake();
    test_bus_contention();
    test_write_reset();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
